// File: rtl/avalon_pio_in_slave.sv
// ---------------------------------------------------------------------------
// avalon_pio_in_slave
//
// Avalon-MM slave exposing WIDTH asynchronous input pins. Each pin is
// synchronized, edge-detected and optionally latched into a sticky
// capture register that can raise a level interrupt.
//
// Register map (word addresses):
//   0 DATA          synchronized pin values (read-only, writes ignored)
//   1 IRQ_MASK      per-bit interrupt enable, bits WIDTH-1:0
//   2 EDGE_CAPTURE  sticky edge flags, write-1-to-clear
//   3 EDGE_CFG      bit0 = capture rising edges, bit1 = capture falling edges
//
// Ports:
//   clk_clk            single rising-edge clock
//   reset_reset        synchronous active-high reset
//   avs_address        word address
//   avs_read/avs_write Avalon-MM requests
//   avs_writedata      write data
//   avs_readdata       read data, qualified by avs_readdatavalid
//   avs_readdatavalid  one-cycle read response strobe
//   avs_waitrequest    stall to the master
//   pio_in             asynchronous external inputs
//   irq                registered level interrupt
// ---------------------------------------------------------------------------
module avalon_pio_in_slave #(
  parameter int WIDTH = 10
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             avs_waitrequest,
  input  logic [WIDTH-1:0] pio_in,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CAP  = 2'd2;
  localparam logic [1:0] ADDR_CFG  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RWAIT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [WIDTH-1:0] cap_reg, cap_next;
  logic [WIDTH-1:0] mask_reg;
  logic [1:0]       cfg_reg;
  logic [1:0]       settle_reg;
  logic [1:0]       addr_reg;
  logic [31:0]      rdata_reg;
  logic             rdv_reg;
  logic             irq_reg;

  logic             wait_next;
  logic             wr_en;
  logic             settled;
  logic [WIDTH-1:0] rise, fall, w1c;
  logic [31:0]      reg_val;
  logic             unused_wdata;

  // Only part of the write bus is stored for narrow configurations.
  assign unused_wdata = ^avs_writedata;

  // Writes land only in IDLE; a simultaneous read takes priority.
  assign wr_en   = (state_reg == S_IDLE) && avs_write && !avs_read;
  assign rise    = sync2_reg & ~prev_reg;
  assign fall    = ~sync2_reg & prev_reg;
  // Suppress capture while the freshly reset synchronizer fills up, so pins
  // already high at release do not look like rising edges.
  assign settled = (settle_reg == 2'd0);
  assign w1c     = (wr_en && avs_address == ADDR_CAP) ? avs_writedata[WIDTH-1:0] : '0;

  // Per-bit capture: a new enabled edge beats a same-cycle W1C clear.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cap
      assign cap_next[gi] = (settled && ((cfg_reg[0] && rise[gi]) || (cfg_reg[1] && fall[gi])))
                          || (cap_reg[gi] && !w1c[gi]);
    end
  endgenerate

  // Register read mux, evaluated during RWAIT.
  always_comb begin
    reg_val = '0;
    case (addr_reg)
      ADDR_DATA: reg_val[WIDTH-1:0] = sync2_reg;
      ADDR_MASK: reg_val[WIDTH-1:0] = mask_reg;
      ADDR_CAP:  reg_val[WIDTH-1:0] = cap_reg;
      ADDR_CFG:  reg_val[1:0]       = cfg_reg;
      default:   reg_val            = '0;
    endcase
  end

  // Bus FSM next-state and waitrequest.
  always_comb begin
    state_next = state_reg;
    wait_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (avs_read) begin
          wait_next  = 1'b1;
          state_next = S_RWAIT;
        end
      end
      S_RWAIT: begin
        // Read is accepted here; any write presented alone is stalled.
        wait_next  = avs_write && !avs_read;
        state_next = S_RESP;
      end
      S_RESP: begin
        wait_next  = avs_read || avs_write;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg  <= S_IDLE;
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      prev_reg   <= '0;
      cap_reg    <= '0;
      mask_reg   <= '0;
      cfg_reg    <= '0;
      settle_reg <= 2'd3;
      addr_reg   <= '0;
      rdata_reg  <= '0;
      rdv_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync1_reg <= pio_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      cap_reg   <= cap_next;
      irq_reg   <= |(cap_reg & mask_reg);
      if (!settled) begin
        settle_reg <= settle_reg - 2'd1;
      end
      if (state_reg == S_IDLE && avs_read) begin
        addr_reg <= avs_address;
      end
      rdv_reg <= (state_reg == S_RWAIT);
      if (state_reg == S_RWAIT) begin
        rdata_reg <= reg_val;
      end
      if (wr_en && avs_address == ADDR_MASK) begin
        mask_reg <= avs_writedata[WIDTH-1:0];
      end
      if (wr_en && avs_address == ADDR_CFG) begin
        cfg_reg <= avs_writedata[1:0];
      end
    end
  end

  assign avs_readdata      = rdata_reg;
  assign avs_readdatavalid = rdv_reg;
  assign avs_waitrequest   = wait_next && !reset_reset;
  assign irq               = irq_reg;

endmodule

// File: tb/tb_avalon_pio_in_slave.sv
// ---------------------------------------------------------------------------
// tb_avalon_pio_in_slave
//
// Directed bench for avalon_pio_in_slave (WIDTH=10). Expected read data is
// queued when a read is issued and compared when readdatavalid appears.
// ---------------------------------------------------------------------------
module tb_avalon_pio_in_slave;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic [9:0]  pio_in;
  logic        irq;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  always #5 clk_clk = ~clk_clk;

  avalon_pio_in_slave #(.WIDTH(10)) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest  (avs_waitrequest),
    .pio_in           (pio_in),
    .irq              (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  // Issues a read (optionally with a colliding write), checks the
  // waitrequest profile, the 3-cycle latency and the single-cycle pulse.
  task automatic do_read(input string tag, input logic [1:0] a, input logic [31:0] exp,
                         input logic wr, input logic [31:0] wd);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp);
    avs_address   = a;
    avs_read      = 1'b1;
    avs_write     = wr;
    avs_writedata = wd;
    @(negedge clk_clk);
    chk({tag, "_wr0"}, {31'd0, avs_waitrequest}, 32'd1);
    tick();
    @(negedge clk_clk);
    chk({tag, "_wr1"}, {31'd0, avs_waitrequest}, 32'd0);
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    n = 0;
    while (!avs_readdatavalid && n < 4) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 32'd0);
    e = exp_q.pop_front();
    if (avs_readdatavalid) chk(tag, avs_readdata, e);
    tick();
    chk({tag, "_pulse"}, {31'd0, avs_readdatavalid}, 32'd0);
  endtask

  initial begin
    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    pio_in        = '0;
    ticks(3);
    reset_reset = 1'b0;

    // Reset state
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdv", {31'd0, avs_readdatavalid}, 32'd0);
    chk("rst_wait", {31'd0, avs_waitrequest}, 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    do_read("rst_data", 2'd0, 32'd0, 1'b0, 32'd0);
    do_read("rst_mask", 2'd1, 32'd0, 1'b0, 32'd0);
    do_read("rst_cap", 2'd2, 32'd0, 1'b0, 32'd0);
    do_read("rst_cfg", 2'd3, 32'd0, 1'b0, 32'd0);

    // DATA read with 0x2A5 held; DATA ignores writes
    pio_in = 10'h2A5;
    ticks(3);
    do_read("data_2a5", 2'd0, 32'h0000_02A5, 1'b0, 32'd0);
    do_write(2'd0, 32'h0000_0123);
    do_read("data_ro", 2'd0, 32'h0000_02A5, 1'b0, 32'd0);
    pio_in = '0;
    ticks(3);

    // Register widths
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read("mask_width", 2'd1, 32'h0000_03FF, 1'b0, 32'd0);
    do_write(2'd3, 32'hFFFF_FFFF);
    do_read("cfg_width", 2'd3, 32'h0000_0003, 1'b0, 32'd0);
    do_write(2'd3, 32'd1);
    do_write(2'd1, 32'h0000_0004);

    // Rising edge on bit 2: capture 3 cycles after pin, irq one later
    pio_in[2] = 1'b1;
    tick(); chk("irq_e1", {31'd0, irq}, 32'd0);
    tick(); chk("irq_e2", {31'd0, irq}, 32'd0);
    tick(); chk("irq_e3", {31'd0, irq}, 32'd0);
    tick(); chk("irq_e4", {31'd0, irq}, 32'd1);
    do_read("cap_rise", 2'd2, 32'h0000_0004, 1'b0, 32'd0);
    do_read("cap_sticky", 2'd2, 32'h0000_0004, 1'b0, 32'd0);
    do_write(2'd2, 32'h0000_0004);
    chk("irq_w1c_1", {31'd0, irq}, 32'd1);
    tick(); chk("irq_w1c_2", {31'd0, irq}, 32'd0);
    do_read("cap_clr", 2'd2, 32'd0, 1'b0, 32'd0);

    // Falling-edge capture
    do_write(2'd3, 32'd2);
    pio_in[2] = 1'b0;
    ticks(4);
    do_read("cap_fall", 2'd2, 32'h0000_0004, 1'b0, 32'd0);
    chk("irq_fall", {31'd0, irq}, 32'd1);
    do_write(2'd2, 32'h0000_0004);
    tick();
    do_read("cap_fall_clr", 2'd2, 32'd0, 1'b0, 32'd0);
    do_write(2'd3, 32'd1);

    // Same-cycle W1C and new edge on bit 0: set wins
    do_write(2'd1, 32'd1);
    pio_in[0] = 1'b1;
    ticks(4);
    chk("irq_b0", {31'd0, irq}, 32'd1);
    pio_in[0] = 1'b0;
    ticks(4);
    pio_in[0] = 1'b1;
    ticks(2);
    do_write(2'd2, 32'd1);
    chk("irq_race_1", {31'd0, irq}, 32'd1);
    tick(); chk("irq_race_2", {31'd0, irq}, 32'd1);
    do_read("cap_race", 2'd2, 32'd1, 1'b0, 32'd0);

    // Read+write collision: read wins, write dropped
    do_read("rw_collide", 2'd1, 32'd1, 1'b1, 32'h0000_00FF);
    do_read("mask_kept", 2'd1, 32'd1, 1'b0, 32'd0);

    // Reset in RWAIT aborts the read
    avs_address = 2'd0;
    avs_read    = 1'b1;
    tick();
    reset_reset = 1'b1;
    avs_read    = 1'b0;
    tick();
    chk("abort_wait", {31'd0, avs_waitrequest}, 32'd0);
    reset_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_rdv", {31'd0, avs_readdatavalid}, 32'd0);
      tick();
    end
    do_read("mask_rst", 2'd1, 32'd0, 1'b0, 32'd0);

    // Pins high through reset: no false edges
    pio_in      = 10'h3FF;
    reset_reset = 1'b1;
    ticks(3);
    reset_reset = 1'b0;
    do_write(2'd3, 32'd3);
    ticks(6);
    do_read("cap_settle", 2'd2, 32'd0, 1'b0, 32'd0);
    chk("irq_settle", {31'd0, irq}, 32'd0);
    do_read("data_3ff", 2'd0, 32'h0000_03FF, 1'b0, 32'd0);
    pio_in[1] = 1'b0;
    ticks(4);
    do_read("cap_after", 2'd2, 32'h0000_0002, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/avalon_pio_in_slave.md
AVALON_PIO_IN_SLAVE -- requirements
Module: avalon_pio_in_slave

Interface
REQ-001 Parameter WIDTH, default 10: number of PIO input lines, legal range 1..32.
REQ-002 clk_clk  input  1: single clock; all logic rising-edge on clk_clk.
REQ-003 reset_reset  input  1: reset, synchronous to clk_clk, active-high.
REQ-004 avs_address  input  2: word address; 0=DATA, 1=IRQ_MASK, 2=EDGE_CAPTURE, 3=EDGE_CFG.
REQ-005 avs_read  input  1: Avalon-MM read request.
REQ-006 avs_write  input  1: Avalon-MM write request.
REQ-007 avs_writedata  input  32: write data.
REQ-008 avs_readdata  output  32: read data; valid only while avs_readdatavalid=1.
REQ-009 avs_readdatavalid  output  1: one-cycle pulse that qualifies avs_readdata.
REQ-010 avs_waitrequest  output  1: stall indication to the master.
REQ-011 pio_in  input  WIDTH: asynchronous external inputs.
REQ-012 irq  output  1: level interrupt request to the master.

Function
REQ-013 pio_in SHALL pass through a 2-flop synchronizer, then a third register (prev), for edge detection.
REQ-014 Edges: rise[i] = sync[i] & ~prev[i]; fall[i] = ~sync[i] & prev[i].
REQ-015 EDGE_CFG bit0 enables rising capture and bit1 enables falling capture; these are global to all bits. Bits 31:2 SHALL read 0 and ignore writes.
REQ-016 EDGE_CAPTURE[i] SHALL be set to 1 in the cycle after an enabled edge on bit i, and SHALL hold until cleared.
REQ-017 A write to EDGE_CAPTURE SHALL clear each bit written as 1 (W1C). Bits written as 0 are unchanged.
REQ-018 If a capture event and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-019 DATA SHALL return the synchronized value (sync) zero-extended to 32 bits. Pin-to-DATA latency is 2 cycles. Writes to DATA SHALL be ignored.
REQ-020 IRQ_MASK SHALL be read/write on bits WIDTH-1:0; upper bits SHALL read 0.
REQ-021 irq SHALL be registered: irq(t+1) = |(EDGE_CAPTURE(t) & IRQ_MASK(t)).
REQ-022 Bus FSM states are IDLE, RWAIT and RESP.
REQ-023 IDLE: avs_waitrequest SHALL be 0 unless avs_read=1.
REQ-024 IDLE with avs_read=1: assert avs_waitrequest=1, latch avs_address, and go to RWAIT.
REQ-025 RWAIT: avs_waitrequest=0 (read accepted), sample the register value, go to RESP.
REQ-026 RESP: avs_readdatavalid=1 with the sampled data for exactly one cycle, then go to IDLE.
REQ-027 A read therefore takes 3 cycles from request to readdatavalid. A new read SHALL NOT be accepted before IDLE is re-entered.
REQ-028 Writes SHALL be accepted in IDLE with zero wait states and take effect the next cycle.
REQ-029 Writes SHALL be given avs_waitrequest=1 in RWAIT and RESP.
REQ-030 If avs_read and avs_write are both 1 in IDLE, the cycle SHALL be treated as a read and the write dropped.
REQ-031 Read data SHALL reflect register state at the RWAIT cycle, including any capture set in that cycle.
REQ-032 A read of EDGE_CAPTURE SHALL NOT clear it.

Reset
REQ-033 When reset_reset=1 at a clock edge, the following SHALL be 0: all registers, synchronizer and prev flops, avs_readdata, avs_readdatavalid, avs_waitrequest and irq; the FSM SHALL return to IDLE.
REQ-034 Reset mid-read SHALL abort the transaction; no readdatavalid pulse SHALL follow.
REQ-035 For 3 cycles after reset deassertion (settle counter), edge capture SHALL be suppressed so that pins already high at release do not create false edges.
REQ-036 Reset values: EDGE_CFG=0 (capture disabled), IRQ_MASK=0, EDGE_CAPTURE=0.

Verification
REQ-037 Read DATA with pio_in=0x2A5 held: read at cycle 0 -> waitrequest=1 at cycle 0, waitrequest=0 at cycle 1, readdatavalid=1 with readdata=0x000002A5 at cycle 2.
REQ-038 Set EDGE_CFG=1 and IRQ_MASK=0x004, then drive pio_in[2] 0->1 -> EDGE_CAPTURE=0x004 3 cycles after the pin change, irq=1 one cycle later; W1C of 0x004 -> irq=0 2 cycles after the write.
REQ-039 Same-cycle W1C of bit 0 and a new enabled edge on bit 0 -> EDGE_CAPTURE[0] stays 1 and irq stays asserted.
REQ-040 Hold pio_in=0x3FF through reset with EDGE_CFG then set to 3 -> EDGE_CAPTURE reads 0x000 (no false edges).
REQ-041 Assert avs_read and avs_write together at address 1 with writedata 0xFF -> a read is returned and IRQ_MASK is unchanged; assert reset in RWAIT -> no readdatavalid pulse.
